phase_sweep_ctrl: RTL and testbench
===================================

# phase_sweep_ctrl

Sequencer for the phase accumulator's frequency-word input. On a start command it clears the accumulator and steps the frequency word from a start value to a stop value in fixed increments, holding each value for a programmable dwell time. The result is a linear stepped chirp. It sits directly in front of the phase accumulator and drives its clear, add/subtract and increment inputs.

## Interface
- WIDTH, 16: frequency-word width; matches the accumulator's D width.
- DWELL_W, 16: dwell-counter and step-counter width.

- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  terminate sweep; sampled in every state.
- f_start  in  WIDTH  first frequency word.
- f_stop  in  WIDTH  last frequency word.
- f_step  in  WIDTH  increment magnitude per step.
- dwell  in  DWELL_W  cycles per frequency; 0 is treated as 1.
- dir  in  1  0 = sweep up, 1 = sweep down.
- neg  in  1  accumulator direction for the whole sweep; drives acc_add_sub.
- acc_clr  out  1  accumulator clear, one-cycle pulse.
- acc_add_sub  out  1  accumulator add/subtract select.
- acc_D  out  WIDTH  accumulator increment (frequency word).
- busy  out  1  high in DWELL state.
- done  out  1  one-cycle pulse when a sweep completes normally.
- step_cnt  out  DWELL_W  number of steps taken in the current or last sweep.

## Operation
- All outputs are registered.
- Reset values:
  - acc_clr=0, acc_add_sub=0, acc_D=0, busy=0, done=0, step_cnt=0.
  - State is IDLE.
- States are IDLE, DWELL and DONE.
- IDLE to DWELL on start=1 and abort=0:
  - Latch f_start, f_stop, f_step, dwell, dir and neg.
  - Load acc_D=f_start, assert acc_clr, set acc_add_sub=neg, busy=1, step_cnt=0.
  - Load the dwell counter with max(dwell,1).
- DWELL:
  - The dwell counter decrements every cycle.
  - acc_clr is high only in the first DWELL cycle of the sweep.
  - Inputs other than abort are ignored; later config changes have no effect until the next start.
- End of dwell, on the last cycle with counter=1:
  - Reached test: acc_D >= f_stop_l when dir=0; acc_D <= f_stop_l when dir=1.
  - If reached, or f_step_l=0, go to DONE.
  - Otherwise compute next = acc_D + f_step_l (up) or acc_D - f_step_l (down) in WIDTH+1 bits.
  - If next passes f_stop_l, or the carry/borrow bit is set, load acc_D=f_stop_l (clamp); else load acc_D=next.
  - Increment step_cnt and reload the dwell counter.
- Mis-ordered config (dir=0 with f_stop<f_start, or dir=1 with f_stop>f_start): one dwell at f_start, then DONE, step_cnt=0.
- DONE, lasting one cycle:
  - done=1, busy=0, acc_D=0, acc_add_sub=0.
  - step_cnt is held.
  - Next state is IDLE.
- abort=1 in any state: next state is IDLE.
  - acc_D=0, acc_clr=0, acc_add_sub=0, busy=0.
  - No done pulse; step_cnt is held.
- start and abort together in IDLE: abort wins and start is ignored.
- start in DWELL or DONE is ignored; it is not queued.
- Reset mid-sweep: immediate return to reset values with no done pulse.

## Timing
- start is sampled at edge E0. From E0, acc_D=f_start, acc_clr=1 and busy=1 are visible for the following cycle; acc_clr drops at E1.
- Each frequency word is held for exactly max(dwell,1) cycles.
- The frequency-word change and the step_cnt increment appear at the same edge.
- Total busy time is (N+1)·max(dwell,1) cycles, where N is the final step_cnt.
- done goes high at the edge that ends the last dwell, lasts one cycle, and coincides with busy=0 and acc_D=0.
- The earliest next start is sampled at the edge after done; back-to-back sweeps therefore have a one-cycle gap.
- abort takes effect at the next edge, 1-cycle latency.

## Test plan
- Basic up sweep:
  - Stimulus: reset released, then start with f_start=1000, f_stop=1300, f_step=100, dwell=4, dir=0, neg=0.
  - Response: acc_D=1000,1100,1200,1300 each for 4 cycles; acc_clr high only in cycle 1; busy for 16 cycles; done pulses once; step_cnt=3; acc_D=0 after.
- Clamp and overflow cases:
  - f_stop=1250, f_step=100 gives acc_D 1000,1100,1200,1250, step_cnt=3.
  - f_start=65000, f_stop=65535, f_step=400 gives 65000,65400,65535, with no wrap to low values.
- Down sweep:
  - Stimulus: f_start=5000, f_stop=4800, f_step=150, dir=1, neg=1, dwell=2.
  - Response: acc_D 5000,4850,4800 each for 2 cycles; acc_add_sub=1 while busy and 0 after done.
- Degenerate config:
  - dwell=0 holds each word 1 cycle.
  - f_step=0 gives a single 1-cycle word at f_start, then done, step_cnt=0.
  - dir=0 with f_stop=500<f_start=1000 gives one dwell at 1000, then done.
- abort, reset and command conflicts:
  - abort during the second dwell: next cycle busy=0, acc_D=0, no done, step_cnt holds 1.
  - start asserted together with abort in IDLE: no sweep.
  - start asserted while busy: ignored.
  - reset asserted mid-sweep: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phase_sweep_ctrl.sv
// Stepped-chirp sequencer: walks the accumulator frequency word from f_start to
// f_stop in f_step increments, holding each word for max(dwell,1) cycles.
module phase_sweep_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   f_start,
  input  logic [WIDTH-1:0]   f_stop,
  input  logic [WIDTH-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dir,
  input  logic               neg,
  output logic               acc_clr,
  output logic               acc_add_sub,
  output logic [WIDTH-1:0]   acc_D,
  output logic               busy,
  output logic               done,
  output logic [DWELL_W-1:0] step_cnt
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t             state_q, state_d;
  logic               acc_clr_q, acc_clr_d;
  logic               acc_add_sub_q, acc_add_sub_d;
  logic [WIDTH-1:0]   acc_d_q, acc_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] step_cnt_q, step_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;
  logic [WIDTH-1:0]   f_stop_q, f_stop_d;
  logic [WIDTH-1:0]   f_step_q, f_step_d;
  logic               dir_q, dir_d;

  logic [WIDTH:0]     next_w;
  logic               clamp;
  logic               reached;
  logic [DWELL_W-1:0] dwell_eff;

  // The extra MSB of next_w is the carry (up) or borrow (down) of the step.
  always_comb begin
    next_w = '0;
    if (dir_q) begin
      next_w = {1'b0, acc_d_q} - {1'b0, f_step_q};
      clamp  = next_w[WIDTH] || (next_w[WIDTH-1:0] < f_stop_q);
    end else begin
      next_w = {1'b0, acc_d_q} + {1'b0, f_step_q};
      clamp  = next_w[WIDTH] || (next_w[WIDTH-1:0] > f_stop_q);
    end
    reached   = dir_q ? (acc_d_q <= f_stop_q) : (acc_d_q >= f_stop_q);
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  end

  always_comb begin
    state_d       = state_q;
    acc_clr_d     = 1'b0;
    acc_add_sub_d = acc_add_sub_q;
    acc_d_d       = acc_d_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    step_cnt_d    = step_cnt_q;
    dwell_cnt_d   = dwell_cnt_q;
    dwell_len_d   = dwell_len_q;
    f_stop_d      = f_stop_q;
    f_step_d      = f_step_q;
    dir_d         = dir_q;

    // abort outranks everything, including a simultaneous start in IDLE.
    if (abort) begin
      state_d       = IDLE;
      acc_add_sub_d = 1'b0;
      acc_d_d       = '0;
      busy_d        = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d       = DWELL;
            acc_clr_d     = 1'b1;
            acc_add_sub_d = neg;
            acc_d_d       = f_start;
            busy_d        = 1'b1;
            step_cnt_d    = '0;
            dwell_cnt_d   = dwell_eff;
            dwell_len_d   = dwell_eff;
            f_stop_d      = f_stop;
            f_step_d      = f_step;
            dir_d         = dir;
          end
        end
        DWELL: begin
          if (dwell_cnt_q == DWELL_W'(1)) begin
            if (reached || (f_step_q == '0)) begin
              state_d       = DONE;
              done_d        = 1'b1;
              busy_d        = 1'b0;
              acc_d_d       = '0;
              acc_add_sub_d = 1'b0;
            end else begin
              acc_d_d     = clamp ? f_stop_q : next_w[WIDTH-1:0];
              step_cnt_d  = step_cnt_q + DWELL_W'(1);
              dwell_cnt_d = dwell_len_q;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d       = IDLE;
          acc_add_sub_d = 1'b0;
          acc_d_d       = '0;
          busy_d        = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_clr_q     <= 1'b0;
      acc_add_sub_q <= 1'b0;
      acc_d_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      step_cnt_q    <= '0;
      dwell_cnt_q   <= '0;
      dwell_len_q   <= '0;
      f_stop_q      <= '0;
      f_step_q      <= '0;
      dir_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_clr_q     <= acc_clr_d;
      acc_add_sub_q <= acc_add_sub_d;
      acc_d_q       <= acc_d_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      step_cnt_q    <= step_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      dwell_len_q   <= dwell_len_d;
      f_stop_q      <= f_stop_d;
      f_step_q      <= f_step_d;
      dir_q         <= dir_d;
    end
  end

  assign acc_clr     = acc_clr_q;
  assign acc_add_sub = acc_add_sub_q;
  assign acc_D       = acc_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed self-checking bench for phase_sweep_ctrl; expected words per sweep
// are hand-computed and listed in each stimulus step.
module tb_phase_sweep_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic        dir;
  logic        neg;
  logic        acc_clr;
  logic        acc_add_sub;
  logic [15:0] acc_D;
  logic        busy;
  logic        done;
  logic [15:0] step_cnt;

  int checks = 0;
  int errors = 0;

  phase_sweep_ctrl #(.WIDTH(16), .DWELL_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .dir(dir), .neg(neg), .acc_clr(acc_clr), .acc_add_sub(acc_add_sub),
    .acc_D(acc_D), .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int fs, input int fe, input int fst,
                               input int dw, input logic d, input logic n);
    f_start = 16'(fs);
    f_stop  = 16'(fe);
    f_step  = 16'(fst);
    dwell   = 16'(dw);
    dir     = d;
    neg     = n;
    start   = 1'b1;
  endtask

  // Runs a whole sweep from the start edge through done and back to IDLE.
  task automatic runSweep(input string name, input int words[8], input int n,
                          input int hold, input logic exp_as);
    tick();
    start = 1'b0;
    f_start = 16'd7;
    f_stop  = 16'd9;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < hold; c++) begin
        checkOutput({name, ".acc_D"}, 32'(acc_D), 32'(words[i]));
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);
        checkOutput({name, ".acc_clr"}, 32'(acc_clr), (i == 0 && c == 0) ? 32'd1 : 32'd0);
        checkOutput({name, ".done"}, 32'(done), 32'd0);
        checkOutput({name, ".acc_add_sub"}, 32'(acc_add_sub), 32'(exp_as));
        checkOutput({name, ".step_cnt"}, 32'(step_cnt), 32'(i));
        tick();
      end
    end
    checkOutput({name, ".done_pulse"}, 32'(done), 32'd1);
    checkOutput({name, ".busy_end"}, 32'(busy), 32'd0);
    checkOutput({name, ".acc_D_end"}, 32'(acc_D), 32'd0);
    checkOutput({name, ".add_sub_end"}, 32'(acc_add_sub), 32'd0);
    checkOutput({name, ".step_cnt_end"}, 32'(step_cnt), 32'(n - 1));
    tick();
    checkOutput({name, ".done_drop"}, 32'(done), 32'd0);
    checkOutput({name, ".step_hold"}, 32'(step_cnt), 32'(n - 1));
  endtask

  initial begin
    int w[8];
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; dir = 1'b0; neg = 1'b0;
    tick();
    tick();
    checkOutput("rst.acc_D", 32'(acc_D), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.step_cnt", 32'(step_cnt), 32'd0);
    checkOutput("rst.acc_clr", 32'(acc_clr), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic up sweep");
    w = '{1000, 1100, 1200, 1300, 0, 0, 0, 0};
    applyStimulus(1000, 1300, 100, 4, 1'b0, 1'b0);
    runSweep("up", w, 4, 4, 1'b0);

    $display("[TB] clamp at f_stop");
    w = '{1000, 1100, 1200, 1250, 0, 0, 0, 0};
    applyStimulus(1000, 1250, 100, 1, 1'b0, 1'b0);
    runSweep("clamp", w, 4, 1, 1'b0);

    $display("[TB] carry overflow clamp");
    w = '{65000, 65400, 65535, 0, 0, 0, 0, 0};
    applyStimulus(65000, 65535, 400, 2, 1'b0, 1'b0);
    runSweep("ovf", w, 3, 2, 1'b0);

    $display("[TB] down sweep");
    w = '{5000, 4850, 4800, 0, 0, 0, 0, 0};
    applyStimulus(5000, 4800, 150, 2, 1'b1, 1'b1);
    runSweep("down", w, 3, 2, 1'b1);

    $display("[TB] dwell zero");
    w = '{10, 13, 16, 0, 0, 0, 0, 0};
    applyStimulus(10, 16, 3, 0, 1'b0, 1'b0);
    runSweep("dw0", w, 3, 1, 1'b0);

    $display("[TB] zero step");
    w = '{700, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(700, 900, 0, 0, 1'b0, 1'b0);
    runSweep("step0", w, 1, 1, 1'b0);

    $display("[TB] misordered config");
    w = '{1000, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(1000, 500, 100, 3, 1'b0, 1'b1);
    runSweep("misord", w, 1, 3, 1'b1);

    $display("[TB] abort in second dwell");
    applyStimulus(1000, 1300, 100, 4, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("abort.pre_acc_D", 32'(acc_D), 32'd1100);
    checkOutput("abort.pre_step", 32'(step_cnt), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.acc_D", 32'(acc_D), 32'd0);
    checkOutput("abort.add_sub", 32'(acc_add_sub), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.step_cnt", 32'(step_cnt), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort.no_done", 32'(done), 32'd0);
      checkOutput("abort.idle_busy", 32'(busy), 32'd0);
    end

    $display("[TB] start with abort in idle");
    applyStimulus(1000, 1300, 100, 4, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("sa.busy", 32'(busy), 32'd0);
    checkOutput("sa.acc_clr", 32'(acc_clr), 32'd0);
    tick();
    checkOutput("sa.busy_later", 32'(busy), 32'd0);

    $display("[TB] start while busy");
    applyStimulus(1000, 1100, 100, 3, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("sb.first_clr", 32'(acc_clr), 32'd1);
    tick();
    start = 1'b1;
    f_start = 16'd2000;
    tick();
    start = 1'b0;
    checkOutput("sb.clr", 32'(acc_clr), 32'd0);
    checkOutput("sb.acc_D", 32'(acc_D), 32'd1000);
    tick();
    checkOutput("sb.next_word", 32'(acc_D), 32'd1100);
    checkOutput("sb.step_cnt", 32'(step_cnt), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("sb.done", 32'(done), 32'd1);
    tick();
    checkOutput("sb.no_restart", 32'(busy), 32'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(1000, 1300, 100, 2, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("mrst.acc_D", 32'(acc_D), 32'd0);
    checkOutput("mrst.busy", 32'(busy), 32'd0);
    checkOutput("mrst.add_sub", 32'(acc_add_sub), 32'd0);
    checkOutput("mrst.step_cnt", 32'(step_cnt), 32'd0);
    checkOutput("mrst.done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("mrst.idle_busy", 32'(busy), 32'd0);
    checkOutput("mrst.idle_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
